branch_predictor_bht: RTL and testbench

Dynamic branch predictor for the pipelined RV32I core. IF looks up the PC each cycle and gets a taken/not-taken prediction with a target. EX sends back the resolved outcome from the conditional-branch evaluator. The block trains its counters and target buffer from that outcome and raises flush/redirect on a misprediction.

---
 rtl/bp_pkg.sv | 16 +
 rtl/sat_counter2.sv | 21 ++
 rtl/branch_predictor_bht.sv | 142 ++++++++++++++
 tb/tb_branch_predictor_bht.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared encodings for the branch predictor: 2-bit saturating counter states,
// the reset value given to every entry and the value written on allocation.
// No ports; imported by branch_predictor_bht and sat_counter2.
package bp_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;  // strongly not-taken
  localparam ctr_t CTR_WNT = 2'b01;  // weakly not-taken
  localparam ctr_t CTR_WT  = 2'b10;  // weakly taken
  localparam ctr_t CTR_ST  = 2'b11;  // strongly taken

  localparam ctr_t CTR_RESET = CTR_WNT;
  localparam ctr_t CTR_ALLOC = CTR_WT;

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating branch counter.
// Latency: purely combinational. Backpressure: none.
// Ports: ctr (current state), taken (resolved outcome), ctr_next (state after training).
module sat_counter2
  import bp_pkg::*;
(
  input  ctr_t ctr,
  input  logic taken,
  output ctr_t ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor_bht.sv
// Direct-mapped branch history table with target buffer for the RV32I fetch stage.
// Latency: lookup and flush/redirect are combinational; training lands on the clock
// edge of the ex_valid cycle. Backpressure: none, one update accepted every cycle.
// Ports: clk/rst (async active-high); if_pc -> pred_taken/pred_target (IF lookup);
// ex_* resolved branch from EX -> flush/redirect_pc.
// Optional BHT_STATS_EN adds stat_branches / stat_mispredicts (32-bit, wrapping).
module branch_predictor_bht
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 4,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
`ifdef BHT_STATS_EN
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts,
`endif
  output logic            flush,
  output logic [XLEN-1:0] redirect_pc
);

  localparam int DEPTH = 1 << INDEX_BITS;
  localparam int TAG_W = XLEN - INDEX_BITS - 2;

  logic             valid_q  [DEPTH];
  logic             valid_d  [DEPTH];
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [TAG_W-1:0] tag_d    [DEPTH];
  logic [XLEN-1:0]  target_q [DEPTH];
  logic [XLEN-1:0]  target_d [DEPTH];
  ctr_t             ctr_q    [DEPTH];
  ctr_t             ctr_d    [DEPTH];

  // ---------------- lookup ----------------
  logic [INDEX_BITS-1:0] if_idx;
  logic [TAG_W-1:0]      if_tag;
  logic                  if_hit;

  assign if_idx = if_pc[INDEX_BITS+1:2];
  assign if_tag = if_pc[XLEN-1:INDEX_BITS+2];
  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

  assign pred_taken  = if_hit && ctr_q[if_idx][1];
  assign pred_target = pred_taken ? target_q[if_idx] : (if_pc + XLEN'(4));

  // ---------------- resolution ----------------
  logic mispredict;

  assign mispredict = (ex_taken != ex_pred_taken) ||
                      (ex_taken && (ex_target != ex_pred_target));

  // Held low while rst is asserted so a stale EX branch cannot redirect fetch.
  assign flush       = ex_valid && !rst && mispredict;
  assign redirect_pc = flush ? (ex_taken ? ex_target : (ex_pc + XLEN'(4))) : '0;

  // ---------------- training ----------------
  logic [INDEX_BITS-1:0] ex_idx;
  logic [TAG_W-1:0]      ex_tag;
  logic                  ex_hit;
  ctr_t                  ctr_trained;

  assign ex_idx = ex_pc[INDEX_BITS+1:2];
  assign ex_tag = ex_pc[XLEN-1:INDEX_BITS+2];
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  sat_counter2 u_sat_counter2 (
    .ctr      (ctr_q[ex_idx]),
    .taken    (ex_taken),
    .ctr_next (ctr_trained)
  );

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (ex_valid) begin
      if (ex_hit) begin
        ctr_d[ex_idx] = ctr_trained;
        if (ex_taken) target_d[ex_idx] = ex_target;
      end else if (ex_taken) begin
        // Miss on a taken branch evicts whatever aliased into this slot.
        valid_d[ex_idx]  = 1'b1;
        tag_d[ex_idx]    = ex_tag;
        target_d[ex_idx] = ex_target;
        ctr_d[ex_idx]    = CTR_ALLOC;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_RESET;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

`ifdef BHT_STATS_EN
  logic [31:0] stat_branches_q,    stat_branches_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  always_comb begin
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (ex_valid) stat_branches_d    = stat_branches_q + 32'd1;
    if (flush)    stat_mispredicts_d = stat_mispredicts_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Self-checking bench for branch_predictor_bht: directed scenarios with literal
// expectations followed by randomized traffic compared every cycle against a
// behavioural table model.
module tb_branch_predictor_bht;

  localparam int IB = 4;
  localparam int XL = 32;
  localparam int N  = 1 << IB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [XL-1:0] if_pc = '0;
  logic          pred_taken;
  logic [XL-1:0] pred_target;
  logic          ex_valid = 1'b0;
  logic [XL-1:0] ex_pc = '0;
  logic          ex_taken = 1'b0;
  logic [XL-1:0] ex_target = '0;
  logic          ex_pred_taken = 1'b0;
  logic [XL-1:0] ex_pred_target = '0;
  logic          flush;
  logic [XL-1:0] redirect_pc;
`ifdef BHT_STATS_EN
  logic [31:0]   stat_branches;
  logic [31:0]   stat_mispredicts;
`endif

  branch_predictor_bht #(.INDEX_BITS(IB), .XLEN(XL)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
`ifdef BHT_STATS_EN
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts),
`endif
    .flush          (flush),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  // ---------------- behavioural model ----------------
  bit            m_valid  [N];
  logic [XL-1:0] m_tag    [N];
  logic [XL-1:0] m_target [N];
  int            m_ctr    [N];
  logic [31:0]   m_branches;
  logic [31:0]   m_misp;

  function automatic int idx_of(input logic [XL-1:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  function automatic logic [XL-1:0] tag_of(input logic [XL-1:0] pc);
    return pc >> (IB + 2);
  endfunction

  function automatic bit m_hit(input logic [XL-1:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit exp_taken(input logic [XL-1:0] pc);
    return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
  endfunction

  function automatic logic [XL-1:0] exp_target(input logic [XL-1:0] pc);
    return exp_taken(pc) ? m_target[idx_of(pc)] : pc + 32'd4;
  endfunction

  function automatic bit exp_flush();
    if (!ex_valid || rst) return 1'b0;
    return (ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target);
  endfunction

  function automatic logic [XL-1:0] exp_redirect();
    if (!exp_flush()) return '0;
    return ex_taken ? ex_target : ex_pc + 32'd4;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_valid[i]  = 1'b0;
        m_tag[i]    = '0;
        m_target[i] = '0;
        m_ctr[i]    = 1;
      end
      m_branches = '0;
      m_misp     = '0;
    end else if (ex_valid) begin
      int k;
      k = idx_of(ex_pc);
      m_branches = m_branches + 32'd1;
      if (exp_flush()) m_misp = m_misp + 32'd1;
      if (m_hit(ex_pc)) begin
        if (ex_taken) begin
          m_ctr[k]    = (m_ctr[k] < 3) ? m_ctr[k] + 1 : 3;
          m_target[k] = ex_target;
        end else begin
          m_ctr[k] = (m_ctr[k] > 0) ? m_ctr[k] - 1 : 0;
        end
      end else if (ex_taken) begin
        m_valid[k]  = 1'b1;
        m_tag[k]    = tag_of(ex_pc);
        m_target[k] = ex_target;
        m_ctr[k]    = 2;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("pred_taken",  {31'd0, pred_taken}, {31'd0, exp_taken(if_pc)});
    chk("pred_target", pred_target, exp_target(if_pc));
    chk("flush",       {31'd0, flush}, {31'd0, exp_flush()});
    chk("redirect_pc", redirect_pc, exp_redirect());
`ifdef BHT_STATS_EN
    chk("stat_branches",    stat_branches,    m_branches);
    chk("stat_mispredicts", stat_mispredicts, m_misp);
`endif
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [XL-1:0] pc, input logic t,
                        input logic [XL-1:0] tg, input logic pt, input logic [XL-1:0] ptg);
    ex_valid = v; ex_pc = pc; ex_taken = t; ex_target = tg;
    ex_pred_taken = pt; ex_pred_target = ptg;
  endtask

  function automatic logic [XL-1:0] rand_pc();
    return 32'h1000 + (32'($urandom_range(0, 63)) << 2);
  endfunction

  initial begin
    rst = 1'b1;
    if_pc = 32'h100;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Cold lookup and +4 wrap.
    @(negedge clk);
    chk("lit_cold_pt",  {31'd0, pred_taken}, 32'd0);
    chk("lit_cold_tgt", pred_target, 32'h104);
    cyc();
    if_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    chk("lit_wrap_tgt", pred_target, 32'h0);
    cyc();

    // Cold miss, not taken: no flush, no allocation.
    if_pc = 32'h100;
    set_ex(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h104);
    @(negedge clk);
    chk("lit_nt_flush", {31'd0, flush}, 32'd0);
    cyc();
    ex_valid = 1'b0;
    @(negedge clk);
    chk("lit_nt_pt", {31'd0, pred_taken}, 32'd0);
    cyc();

    // Cold miss, taken: flush, redirect, allocate; same-cycle lookup still old.
    set_ex(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
    @(negedge clk);
    chk("lit_alloc_flush", {31'd0, flush}, 32'd1);
    chk("lit_alloc_redir", redirect_pc, 32'h200);
    chk("lit_same_cycle_pt", {31'd0, pred_taken}, 32'd0);
    cyc();
    ex_valid = 1'b0;
    @(negedge clk);
    chk("lit_alloc_pt",  {31'd0, pred_taken}, 32'd1);
    chk("lit_alloc_tgt", pred_target, 32'h200);
    chk("lit_model_ctr_alloc", 32'(m_ctr[0]), 32'd2);
    cyc();

    // Saturation: 10 -> 11 -> 11 -> 10 -> 01.
    set_ex(1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
    cyc();
    chk("lit_model_ctr_t1", 32'(m_ctr[0]), 32'd3);
    cyc();
    chk("lit_model_ctr_t2", 32'(m_ctr[0]), 32'd3);
    set_ex(1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
    @(negedge clk);
    chk("lit_nt1_flush", {31'd0, flush}, 32'd1);
    chk("lit_nt1_redir", redirect_pc, 32'h104);
    cyc();
    chk("lit_model_ctr_n1", 32'(m_ctr[0]), 32'd2);
    @(negedge clk);
    chk("lit_sat_pt_wt", {31'd0, pred_taken}, 32'd1);
    cyc();
    chk("lit_model_ctr_n2", 32'(m_ctr[0]), 32'd1);
    ex_valid = 1'b0;
    @(negedge clk);
    chk("lit_sat_pt_wnt", {31'd0, pred_taken}, 32'd0);
    cyc();

    // Alias at the same index evicts 0x100.
    set_ex(1'b1, 32'h140, 1'b1, 32'h300, 1'b0, 32'h144);
    cyc();
    ex_valid = 1'b0;
    if_pc = 32'h100;
    @(negedge clk);
    chk("lit_alias_old_pt", {31'd0, pred_taken}, 32'd0);
    cyc();
    if_pc = 32'h140;
    @(negedge clk);
    chk("lit_alias_pt",  {31'd0, pred_taken}, 32'd1);
    chk("lit_alias_tgt", pred_target, 32'h300);
    cyc();

    // Reset mid-update with a populated table.
    set_ex(1'b1, 32'h140, 1'b1, 32'h400, 1'b0, 32'h0);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("lit_rst_pt",    {31'd0, pred_taken}, 32'd0);
    chk("lit_rst_tgt",   pred_target, 32'h144);
    chk("lit_rst_flush", {31'd0, flush}, 32'd0);
`ifdef BHT_STATS_EN
    chk("lit_rst_stat_br", stat_branches, 32'd0);
    chk("lit_rst_stat_mp", stat_mispredicts, 32'd0);
`endif
    cyc();
    ex_valid = 1'b0;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("lit_post_rst_pt", {31'd0, pred_taken}, 32'd0);
    cyc();

    // Randomized traffic; mostly honest predictions so hits and non-flush cycles occur.
    for (int n = 0; n < 3000; n++) begin
      if_pc    = ($urandom_range(0, 1) != 0) ? ex_pc : rand_pc();
      ex_valid = ($urandom_range(0, 3) != 0);
      ex_pc    = rand_pc();
      ex_taken = ($urandom_range(0, 2) != 0);
      ex_target = 32'h2000 + (32'($urandom_range(0, 3)) << 2);
      if ($urandom_range(0, 3) != 0) begin
        ex_pred_taken  = exp_taken(ex_pc);
        ex_pred_target = exp_target(ex_pc);
      end else begin
        ex_pred_taken  = $urandom_range(0, 1) != 0;
        ex_pred_target = 32'h2000 + (32'($urandom_range(0, 3)) << 2);
      end
      if (n % 1000 == 700) begin
        #2 rst = 1'b1;
        cyc();
        rst = 1'b0;
      end else begin
        cyc();
      end
    end

    ex_valid = 1'b0;
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
